mc_ctrl_fsm: RTL and testbench

- Multi-cycle control unit for the 32-bit MIPS-subset datapath: PC, IR/MDR, register file, ALU, sign-extend and shift-left-2 branch/jump target path.
- Sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- Drives every datapath mux select and write enable.
- Stalls on a ready handshake from a variable-latency unified memory.

---
 rtl/mc_ctrl_pkg.sv | 54 +++++
 rtl/mc_ctrl_fsm.sv | 135 +++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes and
// the mux-select codes that the ALU control and datapath muxes decode.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_EXEC      = 4'd7,
    S_R_WB      = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_ADDI  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_RT     = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } src_b_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RSVD   = 2'b11
  } pc_src_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM: walks each instruction through fetch/decode/execute/
// memory/writeback and drives every datapath select and write enable.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic       illegal_o,
  output logic       busy_o
);

  state_t state, next_state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH:  next_state = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode_i)
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_ADDI:      next_state = S_ADDI_EXEC;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  next_state = (opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:    next_state = mem_ready_i ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:    next_state = S_FETCH;
      S_MEM_WR:    next_state = mem_ready_i ? S_FETCH : S_MEM_WR;
      S_EXEC:      next_state = S_R_WB;
      S_R_WB:      next_state = S_FETCH;
      S_ADDI_EXEC: next_state = S_ADDI_WB;
      S_ADDI_WB:   next_state = S_FETCH;
      S_BRANCH:    next_state = S_FETCH;
      S_JUMP:      next_state = S_FETCH;
      default:     next_state = S_IDLE;
    endcase
  end

  // Moore decode except the FETCH strobes and the DECODE illegal flag.
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SRCB_RT;
    alu_op_o        = ALU_ADD;
    pc_source_o     = PC_ALU;
    illegal_o       = 1'b0;
    busy_o          = (state != S_IDLE);
    case (state)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_b_o = SRCB_IMM_SH;
        illegal_o   = !op_legal(opcode_i);
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      S_ADDI_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALU_ADDI;
      end
      S_ADDI_WB: reg_write_o = 1'b1;
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALU_SUB;
        pc_write_cond_o = 1'b1;
        pc_source_o     = PC_ALUOUT;
      end
      S_JUMP: begin
        pc_write_o  = 1'b1;
        pc_source_o = PC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-cycle vector table with a scoreboard
// queue, plus hand-written reset-mid-access and wait-state cycle-count sequences.
module tb_mc_ctrl_fsm;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
    logic       busy;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    outs_t      exp;
  } vec_t;

  typedef struct {
    string name;
    outs_t exp;
  } sb_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] RT = 6'b000000, JMP = 6'b000010, ADDI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  localparam outs_t E_IDLE  = '0;
  localparam outs_t E_FW    = '{mem_read:1'b1, alu_src_b:2'b01, busy:1'b1, default:'0};
  localparam outs_t E_FR    = '{mem_read:1'b1, alu_src_b:2'b01, ir_write:1'b1,
                                pc_write:1'b1, busy:1'b1, default:'0};
  localparam outs_t E_DEC   = '{alu_src_b:2'b11, busy:1'b1, default:'0};
  localparam outs_t E_ILL   = '{alu_src_b:2'b11, illegal:1'b1, busy:1'b1, default:'0};
  localparam outs_t E_MADDR = '{alu_src_a:1'b1, alu_src_b:2'b10, busy:1'b1, default:'0};
  localparam outs_t E_MRD   = '{mem_read:1'b1, iord:1'b1, busy:1'b1, default:'0};
  localparam outs_t E_MWB   = '{reg_write:1'b1, mem_to_reg:1'b1, busy:1'b1, default:'0};
  localparam outs_t E_MWR   = '{mem_write:1'b1, iord:1'b1, busy:1'b1, default:'0};
  localparam outs_t E_EXEC  = '{alu_src_a:1'b1, alu_op:2'b10, busy:1'b1, default:'0};
  localparam outs_t E_RWB   = '{reg_write:1'b1, reg_dst:1'b1, busy:1'b1, default:'0};
  localparam outs_t E_AEX   = '{alu_src_a:1'b1, alu_src_b:2'b10, alu_op:2'b11,
                                busy:1'b1, default:'0};
  localparam outs_t E_AWB   = '{reg_write:1'b1, busy:1'b1, default:'0};
  localparam outs_t E_BR    = '{alu_src_a:1'b1, alu_op:2'b01, pc_write_cond:1'b1,
                                pc_source:2'b01, busy:1'b1, default:'0};
  localparam outs_t E_J     = '{pc_write:1'b1, pc_source:2'b10, busy:1'b1, default:'0};

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [5:0] opcode_i = '0;
  logic       mem_ready_i = 1'b0;
  logic       pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o;
  logic       ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o;
  logic [1:0] alu_src_b_o, alu_op_o, pc_source_o;
  logic       illegal_o, busy_o;
  outs_t      act;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  sb_t  sb[$];

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .iord_o(iord_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_dst_o(reg_dst_o), .reg_write_o(reg_write_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .pc_source_o(pc_source_o), .illegal_o(illegal_o), .busy_o(busy_o)
  );

  assign act = '{pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o,
                 ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o,
                 alu_src_b_o, alu_op_o, pc_source_o, illegal_o, busy_o};

  task automatic add(input logic r, input logic [5:0] op, input logic rdy, input outs_t e);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.exp = e;
    vecs.push_back(v);
  endtask

  // Drive at the falling edge, compare 1 ns later, well clear of the rising edge.
  task automatic step(input logic r, input logic [5:0] op, input logic rdy,
                      input outs_t e, input string nm);
    sb_t s;
    @(negedge clk);
    rst_i = r; opcode_i = op; mem_ready_i = rdy;
    s.name = nm; s.exp = e;
    sb.push_back(s);
    #1;
    s = sb.pop_front();
    checks++;
    if (act !== s.exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", s.name, act, s.exp);
    end
  endtask

  initial begin
    int cyc, waits;
    logic done, in_rd;

    add(1, 6'h00, 0, E_IDLE); add(1, 6'h00, 1, E_IDLE); add(0, 6'h00, 1, E_IDLE);
    // lw, no wait states
    add(0, BAD, 1, E_FR);  add(0, LW, 1, E_DEC);  add(0, LW, 1, E_MADDR);
    add(0, BAD, 1, E_MRD); add(0, BAD, 1, E_MWB);
    // sw with three wait cycles in MEM_WR
    add(0, BAD, 1, E_FR);  add(0, SW, 1, E_DEC);  add(0, SW, 1, E_MADDR);
    add(0, BAD, 0, E_MWR); add(0, BAD, 0, E_MWR); add(0, BAD, 0, E_MWR);
    add(0, BAD, 1, E_MWR);
    // beq
    add(0, BAD, 1, E_FR);  add(0, BEQ, 1, E_DEC); add(0, BAD, 0, E_BR);
    // R-type then j
    add(0, BAD, 1, E_FR);  add(0, RT, 1, E_DEC);  add(0, BAD, 1, E_EXEC);
    add(0, BAD, 1, E_RWB); add(0, BAD, 1, E_FR);  add(0, JMP, 1, E_DEC);
    add(0, BAD, 0, E_J);
    // fetch waits then addi
    add(0, BAD, 0, E_FW);  add(0, BAD, 0, E_FW);  add(0, BAD, 1, E_FR);
    add(0, ADDI, 1, E_DEC); add(0, BAD, 1, E_AEX); add(0, BAD, 1, E_AWB);
    // illegal opcode, then j
    add(0, BAD, 1, E_FR);  add(0, BAD, 1, E_ILL); add(0, BAD, 1, E_FR);
    add(0, JMP, 1, E_DEC); add(0, BAD, 1, E_J);

    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].op, vecs[i].rdy, vecs[i].exp, $sformatf("vec%0d", i));

    // lw with two MEM_RD wait cycles: 5 + 2 cycles until the next fetch
    cyc = 0; waits = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      rst_i = 1'b0; opcode_i = LW;
      in_rd = mem_read_o && iord_o;
      mem_ready_i = !(in_rd && waits < 2);
      if (in_rd && waits < 2) waits++;
      #1;
      cyc++;
      if (i > 0 && mem_read_o && !iord_o) done = 1'b1;
    end
    checks++;
    if (!done || cyc - 1 != 7) begin
      errors++;
      $display("FAIL lw_wait_cycles: got %0d (done=%0b) want 7", cyc - 1, done);
    end

    // reset asserted mid-MEM_RD
    step(0, LW,  1, E_DEC,   "rst_seq_dec");
    step(0, LW,  1, E_MADDR, "rst_seq_maddr");
    step(0, BAD, 0, E_MRD,   "rst_seq_mrd");
    step(1, BAD, 1, E_IDLE,  "rst_mid_rd");
    step(1, BAD, 1, E_IDLE,  "rst_held");
    step(0, BAD, 0, E_IDLE,  "post_rst_idle");
    step(0, BAD, 0, E_FW,    "post_rst_fetch");

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
